// File: rtl/pe_array_ctrl_pkg.sv
// Shared PE command/state codes, array defaults and controller state enum
// for the PE array controller.
package pe_array_ctrl_pkg;

   localparam int unsigned PE_CMD_BITS   = 2;
   localparam int unsigned PE_STATE_BITS = 1;

   localparam logic [PE_CMD_BITS-1:0] PE_CMD_NOP     = 2'd0;
   localparam logic [PE_CMD_BITS-1:0] PE_CMD_WRITE   = 2'd1;
   localparam logic [PE_CMD_BITS-1:0] PE_CMD_READ    = 2'd2;
   localparam logic [PE_CMD_BITS-1:0] PE_CMD_PROCESS = 2'd3;

   localparam logic [PE_STATE_BITS-1:0] PE_STATE_DEAD = 1'b0;
   localparam logic [PE_STATE_BITS-1:0] PE_STATE_LIVE = 1'b1;

   localparam int unsigned PE_ROWS_DEFAULT = 16;
   localparam int unsigned PE_COLS_DEFAULT = 16;
   localparam int unsigned GEN_BITS        = 16;
   localparam int unsigned GAP_BITS        = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_READ    = 3'd2,
      ST_RWAIT   = 3'd3,
      ST_RACK    = 3'd4,
      ST_PROCESS = 3'd5,
      ST_PAUSE   = 3'd6,
      ST_DONE    = 3'd7
   } ctrl_state_e;

   // Index width for an axis of n elements; never narrower than one bit.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_array_ctrl_sel_dec.sv
// Index to one-hot decoder with enable; indices past the axis length select nothing.
module pe_sel_dec #(
   parameter int unsigned N  = 16,
   parameter int unsigned IW = 4
) (
   input  logic          en,
   input  logic [IW-1:0] idx,
   output logic [N-1:0]  sel_c,
   output logic          in_range_c
);

   always_comb begin
      in_range_c = (32'(idx) < N);
      sel_c      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (en && (32'(idx) == i)) sel_c[i] = 1'b1;
      end
   end

endmodule

// File: rtl/pe_array_ctrl.sv
// Host-facing controller for a PE array: single-cell write/read access and
// paced multi-generation runs with abort and early stop on a stable array.
module pe_array_ctrl
   import pe_array_ctrl_pkg::*;
#(
   parameter  int unsigned ROWS = PE_ROWS_DEFAULT,
   parameter  int unsigned COLS = PE_COLS_DEFAULT,
   localparam int unsigned RW   = idx_bits(ROWS),
   localparam int unsigned CW   = idx_bits(COLS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_req,
   input  logic [RW-1:0]            wr_row,
   input  logic [CW-1:0]            wr_col,
   input  logic [PE_STATE_BITS-1:0] wr_data,
   output logic                     wr_ack,
   input  logic                     rd_req,
   input  logic [RW-1:0]            rd_row,
   input  logic [CW-1:0]            rd_col,
   output logic                     rd_ack,
   output logic [PE_STATE_BITS-1:0] rd_data,
   input  logic                     start,
   input  logic [GEN_BITS-1:0]      gen_count,
   input  logic [GAP_BITS-1:0]      gap,
   input  logic                     abort,
   output logic [PE_CMD_BITS-1:0]   cmd,
   output logic [ROWS-1:0]          rsel,
   output logic [COLS-1:0]          csel,
   output logic [PE_STATE_BITS-1:0] state_wr,
   input  logic [PE_STATE_BITS-1:0] array_rdata,
   input  logic                     active_any,
   output logic                     busy,
   output logic                     done,
   output logic                     stable,
   output logic [GEN_BITS-1:0]      gens_run
);

   localparam logic [GEN_BITS-1:0] GEN_MAX = '1;

   ctrl_state_e state, state_next;

   logic [GEN_BITS-1:0] n_q, n_d;
   logic [GAP_BITS-1:0] g_q, g_d;
   logic [GAP_BITS-1:0] pause_q, pause_d;
   logic                rd_ok_q, rd_ok_d;

   logic [PE_CMD_BITS-1:0]   cmd_d;
   logic [ROWS-1:0]          rsel_d;
   logic [COLS-1:0]          csel_d;
   logic [PE_STATE_BITS-1:0] state_wr_d, rd_data_d;
   logic                     wr_ack_d, rd_ack_d, busy_d, done_d, stable_d;
   logic [GEN_BITS-1:0]      gens_run_d, gens_base;

   logic            sel_en_c, row_ok_c, col_ok_c, run_acc_c;
   logic [RW-1:0]   row_idx_c;
   logic [CW-1:0]   col_idx_c;
   logic [ROWS-1:0] rsel_dec_c;
   logic [COLS-1:0] csel_dec_c;

   // Selects are decoded straight from the host request on the accepting edge.
   always_comb begin
      row_idx_c = wr_req ? wr_row : rd_row;
      col_idx_c = wr_req ? wr_col : rd_col;
      sel_en_c  = (state == ST_IDLE) &&
                  ((state_next == ST_WRITE) || (state_next == ST_READ));
      run_acc_c = (state == ST_IDLE) &&
                  ((state_next == ST_PROCESS) || (state_next == ST_DONE));
   end

   pe_sel_dec #(.N(ROWS), .IW(RW)) u_row_dec (
      .en         (sel_en_c),
      .idx        (row_idx_c),
      .sel_c      (rsel_dec_c),
      .in_range_c (row_ok_c)
   );

   pe_sel_dec #(.N(COLS), .IW(CW)) u_col_dec (
      .en         (sel_en_c),
      .idx        (col_idx_c),
      .sel_c      (csel_dec_c),
      .in_range_c (col_ok_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (wr_req)      state_next = ST_WRITE;
            else if (rd_req) state_next = ST_READ;
            else if (start)  state_next = (gen_count == '0) ? ST_DONE : ST_PROCESS;
         end
         ST_WRITE: state_next = ST_IDLE;
         ST_READ:  state_next = ST_RWAIT;
         ST_RWAIT: state_next = ST_RACK;
         ST_RACK:  state_next = ST_IDLE;
         // gens_run already counts the generation being processed this cycle
         ST_PROCESS: begin
            if (!active_any || (gens_run >= n_q) || abort) state_next = ST_DONE;
            else if (g_q == '0)                            state_next = ST_PROCESS;
            else                                           state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (abort)                          state_next = ST_DONE;
            else if (pause_q <= GAP_BITS'(1))   state_next = ST_PROCESS;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_d      = PE_CMD_NOP;
      rsel_d     = rsel_dec_c;
      csel_d     = csel_dec_c;
      state_wr_d = state_wr;
      wr_ack_d   = 1'b0;
      rd_ack_d   = 1'b0;
      rd_data_d  = rd_data;
      busy_d     = (state_next != ST_IDLE);
      done_d     = (state == ST_DONE);
      stable_d   = stable;
      gens_run_d = gens_run;
      gens_base  = gens_run;
      n_d        = n_q;
      g_d        = g_q;
      pause_d    = pause_q;
      rd_ok_d    = rd_ok_q;

      if (run_acc_c) begin
         n_d        = gen_count;
         g_d        = gap;
         gens_run_d = '0;
         gens_base  = '0;
         stable_d   = 1'b0;
      end
      if ((state == ST_PROCESS) && !active_any) stable_d = 1'b1;

      unique case (state_next)
         ST_WRITE: begin
            cmd_d      = PE_CMD_WRITE;
            state_wr_d = wr_data;
            wr_ack_d   = 1'b1;
         end
         ST_READ: begin
            cmd_d   = PE_CMD_READ;
            rd_ok_d = row_ok_c && col_ok_c;
         end
         ST_RACK: begin
            rd_ack_d  = 1'b1;
            rd_data_d = rd_ok_q ? array_rdata : '0;
         end
         ST_PROCESS: begin
            cmd_d      = PE_CMD_PROCESS;
            gens_run_d = (gens_base == GEN_MAX) ? gens_base : gens_base + GEN_BITS'(1);
         end
         ST_PAUSE: pause_d = (state == ST_PAUSE) ? pause_q - GAP_BITS'(1) : g_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd      <= PE_CMD_NOP;
         rsel     <= '0;
         csel     <= '0;
         state_wr <= '0;
         wr_ack   <= 1'b0;
         rd_ack   <= 1'b0;
         rd_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         stable   <= 1'b0;
         gens_run <= '0;
         n_q      <= '0;
         g_q      <= '0;
         pause_q  <= '0;
         rd_ok_q  <= 1'b0;
      end else begin
         cmd      <= cmd_d;
         rsel     <= rsel_d;
         csel     <= csel_d;
         state_wr <= state_wr_d;
         wr_ack   <= wr_ack_d;
         rd_ack   <= rd_ack_d;
         rd_data  <= rd_data_d;
         busy     <= busy_d;
         done     <= done_d;
         stable   <= stable_d;
         gens_run <= gens_run_d;
         n_q      <= n_d;
         g_q      <= g_d;
         pause_q  <= pause_d;
         rd_ok_q  <= rd_ok_d;
      end
   end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: a Game-of-Life PE array model driven by the command
// bus, with host reads, writes and runs checked against a shadow grid.
module tb_pe_array_ctrl;
   import pe_array_ctrl_pkg::*;

   localparam int unsigned ROWS = 12;
   localparam int unsigned COLS = 14;
   localparam int unsigned RW   = 4;
   localparam int unsigned CW   = 4;
   localparam int unsigned NC   = ROWS * COLS;

   logic clk = 1'b0;
   logic rst, wr_req, rd_req, start, abort, active_any, wr_ack, rd_ack, busy, done, stable;
   logic [RW-1:0] wr_row, rd_row;
   logic [CW-1:0] wr_col, rd_col;
   logic [PE_STATE_BITS-1:0] wr_data, rd_data, state_wr, array_rdata;
   logic [GEN_BITS-1:0] gen_count, gens_run;
   logic [GAP_BITS-1:0] gap;
   logic [PE_CMD_BITS-1:0] cmd;
   logic [ROWS-1:0] rsel;
   logic [COLS-1:0] csel;

   int checks = 0;
   int failures = 0;

   pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_ack(rd_ack), .rd_data(rd_data),
      .start(start), .gen_count(gen_count), .gap(gap), .abort(abort),
      .cmd(cmd), .rsel(rsel), .csel(csel), .state_wr(state_wr),
      .array_rdata(array_rdata), .active_any(active_any),
      .busy(busy), .done(done), .stable(stable), .gens_run(gens_run)
   );

   always #5 clk = ~clk;

   // One Life generation on a bounded grid (cells beyond the edge are dead).
   function automatic logic [NC-1:0] life(input logic [NC-1:0] g);
      logic [NC-1:0] n;
      int k, rr, cc;
      n = '0;
      for (int r = 0; r < int'(ROWS); r++)
         for (int c = 0; c < int'(COLS); c++) begin
            k = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < int'(ROWS) && cc >= 0 && cc < int'(COLS))
                     k += int'(g[rr*int'(COLS)+cc]);
               end
            n[r*int'(COLS)+c] = (k == 3) || (k == 2 && g[r*int'(COLS)+c]);
         end
      return n;
   endfunction

   // PE array model: registered read data, active when the next generation differs.
   logic [NC-1:0] grid = '0;
   logic [PE_STATE_BITS-1:0] arr_rd = '0;
   logic acc;
   always @(posedge clk) begin
      case (cmd)
         PE_CMD_WRITE:
            for (int r = 0; r < int'(ROWS); r++)
               for (int c = 0; c < int'(COLS); c++)
                  if (rsel[r] && csel[c]) grid[r*int'(COLS)+c] <= state_wr[0];
         PE_CMD_READ: begin
            acc = 1'b0;
            for (int r = 0; r < int'(ROWS); r++)
               for (int c = 0; c < int'(COLS); c++)
                  if (rsel[r] && csel[c]) acc = acc | grid[r*int'(COLS)+c];
            arr_rd <= acc;
         end
         PE_CMD_PROCESS: grid <= life(grid);
         default: ;
      endcase
   end
   assign array_rdata = arr_rd;
   assign active_any  = (life(grid) != grid);

   logic [NC-1:0] shadow = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd"}, 32'(cmd), 32'(PE_CMD_NOP));
      chk({tag, "_rsel"}, 32'(rsel), 0);
      chk({tag, "_csel"}, 32'(csel), 0);
      chk({tag, "_state_wr"}, 32'(state_wr), 0);
      chk({tag, "_rd_data"}, 32'(rd_data), 0);
      chk({tag, "_acks"}, {30'd0, wr_ack, rd_ack}, 0);
      chk({tag, "_busy_done"}, {30'd0, busy, done}, 0);
      chk({tag, "_stable"}, 32'(stable), 0);
      chk({tag, "_gens_run"}, 32'(gens_run), 0);
   endtask

   function automatic logic [31:0] onehot(input int i, input int n);
      logic [31:0] v;
      v = 32'd1;
      return (i < n) ? (v << i) : 32'd0;
   endfunction

   task automatic host_write(input int r, input int c, input logic d);
      int lat;
      bit got;
      wr_row = RW'(r); wr_col = CW'(c); wr_data = d; wr_req = 1'b1;
      lat = 0; got = 0;
      while (!got && lat < 20) begin
         @(negedge clk); lat++;
         if (wr_ack) begin
            got = 1;
            chk("wr_cmd", 32'(cmd), 32'(PE_CMD_WRITE));
            chk("wr_rsel", 32'(rsel), onehot(r, int'(ROWS)));
            chk("wr_csel", 32'(csel), onehot(c, int'(COLS)));
            chk("wr_state_wr", 32'(state_wr), 32'(d));
         end
      end
      wr_req = 1'b0;
      chk("wr_ack_lat", 32'(lat), 1);
      if (r < int'(ROWS) && c < int'(COLS)) shadow[r*int'(COLS)+c] = d;
      @(negedge clk);
      chk("wr_ack_pulse", 32'(wr_ack), 0);
   endtask

   task automatic host_read(input int r, input int c);
      int lat;
      bit got;
      logic exp;
      exp = (r < int'(ROWS) && c < int'(COLS)) ? shadow[r*int'(COLS)+c] : 1'b0;
      rd_row = RW'(r); rd_col = CW'(c); rd_req = 1'b1;
      lat = 0; got = 0;
      while (!got && lat < 20) begin
         @(negedge clk); lat++;
         if (lat == 1) begin
            chk("rd_cmd", 32'(cmd), 32'(PE_CMD_READ));
            chk("rd_rsel", 32'(rsel), onehot(r, int'(ROWS)));
         end
         if (rd_ack) got = 1;
      end
      rd_req = 1'b0;
      chk("rd_ack_lat", 32'(lat), 3);
      chk("rd_data", 32'(rd_data), 32'(exp));
      @(negedge clk);
      chk("rd_ack_pulse", 32'(rd_ack), 0);
      chk("rd_data_hold", 32'(rd_data), 32'(exp));
   endtask

   // Reference: generation count, stability and done timing derived from the rules.
   task automatic run(input int n, input int g, input int abort_gen);
      logic [NC-1:0] cur, nxt;
      int eg, procs, last_k, abort_k, k, exp_done;
      bit es, got, ab;
      cur = shadow; eg = 0; es = 0;
      while (eg < n) begin
         nxt = life(cur); eg++;
         if (nxt == cur) begin es = 1; break; end
         cur = nxt;
         if (abort_gen > 0 && eg == abort_gen) break;
      end
      ab = (abort_gen > 0) && !es && (eg == abort_gen) && (eg < n);
      gen_count = GEN_BITS'(n); gap = GAP_BITS'(g); start = 1'b1;
      procs = 0; last_k = -1; abort_k = -1; got = 0; k = 0;
      while (!got && k < 3000) begin
         @(negedge clk); k++;
         if (cmd == PE_CMD_PROCESS) begin
            if (procs > 0) chk("proc_spacing", 32'(k - last_k), 32'(g + 1));
            else           chk("first_proc_lat", 32'(k), 1);
            chk("proc_sel", {rsel, csel} == '0 ? 32'd0 : 32'd1, 0);
            procs++; last_k = k;
         end
         if (ab && !abort && busy && cmd == PE_CMD_NOP && gens_run == GEN_BITS'(abort_gen)) begin
            abort = 1'b1; abort_k = k;
         end
         if (done) got = 1;
      end
      start = 1'b0; abort = 1'b0;
      chk("run_done_seen", 32'(got), 1);
      // done is registered out of the DONE state, two edges after the deciding edge
      exp_done = (eg == 0) ? 2 : (ab ? abort_k + 2 : 1 + (eg - 1) * (g + 1) + 2);
      chk("run_done_lat", 32'(k), 32'(exp_done));
      chk("run_gens_run", 32'(gens_run), 32'(eg));
      chk("run_stable", 32'(stable), 32'(es));
      chk("run_proc_count", 32'(procs), 32'(eg));
      chk("run_busy_clear", 32'(busy), 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
      chk("stable_hold", 32'(stable), 32'(es));
      chk("gens_hold", 32'(gens_run), 32'(eg));
      shadow = cur;
   endtask

   initial begin
      int wk, rk, pk, dk, k;
      logic [NC-1:0] s1;
      rst = 1'b1; wr_req = 0; rd_req = 0; start = 0; abort = 0;
      wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0; rd_col = '0;
      gen_count = '0; gap = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // write then read, neighbour reads dead, out-of-range acks with no select
      host_write(3, 5, PE_STATE_LIVE);
      host_read(3, 5);
      host_read(3, 6);
      host_write(13, 2, PE_STATE_LIVE);
      host_read(13, 2);
      host_read(2, 15);
      host_write(3, 5, PE_STATE_DEAD);

      // ignored abort in IDLE
      abort = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 0);
      abort = 1'b0;

      // blinker, two generations back to back
      host_write(4, 3, 1); host_write(4, 4, 1); host_write(4, 5, 1);
      run(2, 0, -1);
      host_read(4, 3); host_read(4, 4); host_read(4, 5); host_read(3, 4);
      host_write(4, 3, 0); host_write(4, 4, 0); host_write(4, 5, 0);

      // still-life block stops after the first generation
      host_write(1, 1, 1); host_write(1, 2, 1); host_write(2, 1, 1); host_write(2, 2, 1);
      run(10, 3, -1);
      host_write(1, 1, 0); host_write(1, 2, 0); host_write(2, 1, 0); host_write(2, 2, 0);

      // paced run aborted in PAUSE after seven generations
      host_write(4, 3, 1); host_write(4, 4, 1); host_write(4, 5, 1);
      run(100, 4, 7);
      host_read(3, 4); host_read(4, 4); host_read(4, 3);

      run(0, 2, -1);

      // simultaneous requests: write, then read, then run
      wr_row = RW'(9); wr_col = CW'(11); wr_data = 1'b1; wr_req = 1'b1;
      rd_row = RW'(4); rd_col = CW'(4); rd_req = 1'b1;
      gen_count = 16'd1; gap = 8'd0; start = 1'b1;
      wk = -1; rk = -1; pk = -1; dk = -1; k = 0;
      while (dk < 0 && k < 60) begin
         @(negedge clk); k++;
         if (wr_ack) begin wk = k; wr_req = 1'b0; shadow[9*int'(COLS)+11] = 1'b1; end
         if (rd_ack) begin
            rk = k; rd_req = 1'b0;
            chk("arb_rd_data", 32'(rd_data), 32'(shadow[4*int'(COLS)+4]));
         end
         if (cmd == PE_CMD_PROCESS && pk < 0) pk = k;
         if (done) begin dk = k; start = 1'b0; end
      end
      start = 1'b0;
      chk("arb_wr_k", 32'(wk), 1);
      chk("arb_rd_k", 32'(rk), 5);
      chk("arb_proc_k", 32'(pk), 7);
      chk("arb_done_k", 32'(dk), 9);
      chk("arb_gens", 32'(gens_run), 1);
      s1 = life(shadow);
      chk("arb_stable", 32'(stable), 32'(s1 == shadow));
      shadow = s1;
      @(negedge clk);

      // randomized traffic
      for (int it = 0; it < 5; it++) begin
         for (int w = 0; w < 6; w++)
            host_write(int'($urandom_range(ROWS - 1, 0)), int'($urandom_range(COLS - 1, 0)),
                       1'($urandom_range(1, 0)));
         for (int r = 0; r < 3; r++)
            host_read(int'($urandom_range(ROWS - 1, 0)), int'($urandom_range(COLS - 1, 0)));
         run(int'($urandom_range(6, 1)), int'($urandom_range(3, 0)), -1);
      end

      // reset during PAUSE abandons the run silently
      host_write(7, 2, 1); host_write(7, 3, 1); host_write(7, 4, 1);
      host_read(7, 3);
      gen_count = 16'd50; gap = 8'd3; start = 1'b1;
      k = 0;
      while (!(busy && cmd == PE_CMD_NOP && gens_run == 16'd2) && k < 100) begin
         @(negedge clk); k++;
      end
      chk("rst_reach_pause", 32'(k < 100), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrun_reset");
      rst = 1'b0; start = 1'b0;
      shadow = life(life(shadow));
      k = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) k++;
      end
      chk("post_reset_quiet", 32'(k), 0);
      host_read(7, 3); host_read(6, 3); host_read(7, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
